ejector: RTL and testbench
==========================

Name: ejector

Overview:
- Ejection stage of the bufferless deflection router; the counterpart of the injector.
- Each cycle it inspects the four incoming link flits and removes at most one whose destination equals the local node address.
- The removed flit goes into a small ejection FIFO that drains to the local core with a valid/ready handshake.
- All flits not ejected pass through, registered, to the permutation/deflection stage.

Parameters:
- DATA_W, 16, payload width in bits.
- FLIT_W, DATA_W+7, flit width: {valid, dst[5:0], payload}.
- DEPTH, 4, ejection FIFO depth in flits; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- local_addr  in  6  this node's address; compared against the flit dst field.
- e_in  in  FLIT_W  flit arriving from east (port index 0).
- w_in  in  FLIT_W  flit arriving from west (index 1).
- n_in  in  FLIT_W  flit arriving from north (index 2).
- s_in  in  FLIT_W  flit arriving from south (index 3).
- e_out  out  FLIT_W  registered pass-through of e_in; valid cleared if ejected.
- w_out  out  FLIT_W  registered pass-through of w_in; same rule.
- n_out  out  FLIT_W  registered pass-through of n_in; same rule.
- s_out  out  FLIT_W  registered pass-through of s_in; same rule.
- eject_grant  out  4  registered one-hot: the index ejected last cycle; 0 = none.
- local_valid  out  1  FIFO head is valid.
- local_flit  out  FLIT_W  FIFO head flit.
- local_ready  in  1  core accepts local_flit when local_valid && local_ready.
- fifo_full  out  1  FIFO holds DEPTH flits.
- eject_cnt  out  16  flits ejected; wraps modulo 2^16.
- miss_cnt  out  16  cycles with at least one local match but no grant; saturates at 16'hFFFF.

Behaviour:
- Match: match[i] = valid[i] && dst[i] == local_addr.
- Grant rule: if the FIFO is not full, grant the first matching index searching from rr_ptr upward, modulo 4.
- Full FIFO: no grant that cycle. A pop in the same cycle does NOT free space for a push. The matching flits stay in the network (deflected).
- rr_ptr: 2-bit register; on a grant it loads (winner+1) mod 4; unchanged otherwise.
- Pass-through: x_out <= x_in with the valid bit forced to 0 for the granted index. Latency is 1 cycle; payload and dst are passed unchanged.
- Push: the granted flit enters the FIFO in the same edge. It is visible on local_flit the next cycle if the FIFO was empty (1-cycle eject-to-local latency).
- Pop: on local_valid && local_ready the head advances.
- Simultaneous push and pop when not full: count is unchanged. When empty, no pop occurs (local_valid=0).
- Pointer and count arithmetic: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Flow control: local_flit is held stable while local_valid && !local_ready.
- eject_cnt increments on every grant.
- miss_cnt increments when |match && no grant.
- Reset, asynchronous and at any time: all x_out=0, eject_grant=0, rr_ptr=0, FIFO emptied (local_valid=0, fifo_full=0), counters=0. Reset mid-stream discards FIFO contents; there is no partial state.
- local_flit while empty is don't-care; it must not be X-propagating into control logic.

Decomposition:
- noc_pkg holds:
  - flit field positions (VALID_BIT, DST_HI/DST_LO, payload slice);
  - direction indices DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3;
  - address width 6.
- Sub-module ejector_fifo (parameters DEPTH, FLIT_W; push/pop/full/empty/head).
- The round-robin select stays inline in ejector.

Test Plan:
- Reset, then local_addr=6'b100100 and n_in={1,6'b100100,16'hA5A5}, other inputs invalid -> next cycle eject_grant=4'b0100, n_out valid=0, local_valid=1, local_flit payload 16'hA5A5, eject_cnt=1.
- All four inputs valid with dst=6'b100100, local_ready=1, held 4 cycles -> grants rotate e,w,n,s (0001, 0010, 0100, 1000); the non-granted flits appear on their outputs with valid=1.
- local_ready=0, one match per cycle for 6 cycles, DEPTH=4 -> fifo_full=1 after 4 grants; cycles 5-6 give eject_grant=0, miss_cnt=2, matching flits pass through valid.
- Full FIFO, local_ready=1 together with a new match -> pop occurs, no grant that cycle; grant resumes next cycle, with the FIFO order preserved (FIFO-order check).
- Inputs with dst=6'b101111, 6'b011001 and a valid=0 flit with dst=6'b100100 -> no grant, all valid flits pass unchanged, counters unchanged.
- rst_n low mid-stream with 3 flits queued -> immediately local_valid=0, outputs 0, counters 0; after release the first grant comes from index 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the deflection router stages.
// Flit layout is {valid, dst[5:0], payload[DATA_W-1:0]}.
package noc_pkg;

  localparam int ADDR_W = 6;
  localparam int NDIR   = 4;

  localparam int DIR_E = 0;
  localparam int DIR_W = 1;
  localparam int DIR_N = 2;
  localparam int DIR_S = 3;

  localparam int DATA_W_DEF = 16;
  localparam int FLIT_W_DEF = DATA_W_DEF + ADDR_W + 1;

  function automatic int valid_bit(input int dw);
    return dw + ADDR_W;
  endfunction

  function automatic int dst_hi(input int dw);
    return dw + ADDR_W - 1;
  endfunction

  function automatic int dst_lo(input int dw);
    return dw;
  endfunction

  function automatic int pay_hi(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/ejector_fifo.sv
// Ejection FIFO between the ejector and the local core.
// Storage is reset so an empty head never carries X.
module ejector_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [FLIT_W-1:0] i_din,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [FLIT_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rp];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ejector.sv
// Ejection stage: removes at most one locally addressed flit
// per cycle (round-robin) and registers the rest onward.
module ejector
  import noc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLIT_W = DATA_W + 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] local_addr,
  input  logic [FLIT_W-1:0] e_in,
  input  logic [FLIT_W-1:0] w_in,
  input  logic [FLIT_W-1:0] n_in,
  input  logic [FLIT_W-1:0] s_in,
  output logic [FLIT_W-1:0] e_out,
  output logic [FLIT_W-1:0] w_out,
  output logic [FLIT_W-1:0] n_out,
  output logic [FLIT_W-1:0] s_out,
  output logic [NDIR-1:0]   eject_grant,
  output logic              local_valid,
  output logic [FLIT_W-1:0] local_flit,
  input  logic              local_ready,
  output logic              fifo_full,
  output logic [15:0]       eject_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int VB = valid_bit(DATA_W);
  localparam int DH = dst_hi(DATA_W);
  localparam int DL = dst_lo(DATA_W);

  logic [FLIT_W-1:0] w_flit [NDIR];
  logic [FLIT_W-1:0] w_pass [NDIR];
  logic [NDIR-1:0]   w_match;
  logic              w_gnt;
  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic [NDIR-1:0]   w_oh;
  logic              w_full;
  logic              w_empty;

  logic [FLIT_W-1:0] r_out [NDIR];
  logic [NDIR-1:0]   r_grant;
  logic [1:0]        r_rr_ptr;
  logic [15:0]       r_ecnt;
  logic [15:0]       r_mcnt;

  assign w_flit[DIR_E] = e_in;
  assign w_flit[DIR_W] = w_in;
  assign w_flit[DIR_N] = n_in;
  assign w_flit[DIR_S] = s_in;

  always_comb begin
    for (int i = 0; i < NDIR; i++) begin
      w_match[i] = w_flit[i][VB]
                && (w_flit[i][DH:DL] == local_addr);
    end
  end

  // First match at or after r_rr_ptr; a full FIFO blocks all grants.
  always_comb begin
    w_gnt = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_oh  = '0;
    for (int k = 0; k < NDIR; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_full && !w_gnt && w_match[w_idx]) begin
        w_gnt = 1'b1;
        w_win = w_idx;
      end
    end
    if (w_gnt) begin
      w_oh[w_win] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NDIR; i++) begin
      w_pass[i]     = w_flit[i];
      w_pass[i][VB] = w_flit[i][VB] & ~w_oh[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIR; i++) begin
        r_out[i] <= '0;
      end
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_ecnt   <= '0;
      r_mcnt   <= '0;
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        r_out[i] <= w_pass[i];
      end
      r_grant <= w_oh;
      if (w_gnt) begin
        r_rr_ptr <= w_win + 2'd1;
        r_ecnt   <= r_ecnt + 16'd1;
      end
      if (|w_match && !w_gnt && r_mcnt != 16'hFFFF) begin
        r_mcnt <= r_mcnt + 16'd1;
      end
    end
  end

  ejector_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_gnt),
    .i_din   (w_flit[w_win]),
    .i_pop   (local_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (local_flit)
  );

  assign e_out       = r_out[DIR_E];
  assign w_out       = r_out[DIR_W];
  assign n_out       = r_out[DIR_N];
  assign s_out       = r_out[DIR_S];
  assign eject_grant = r_grant;
  assign local_valid = !w_empty;
  assign fifo_full   = w_full;
  assign eject_cnt   = r_ecnt;
  assign miss_cnt    = r_mcnt;

endmodule

// File: tb/tb_ejector.sv
// Scoreboard bench for the ejector: queue-based reference model
// produces per-cycle expectations, a monitor compares them.
module tb_ejector;
  import noc_pkg::*;

  localparam int DW = 16;
  localparam int FW = 23;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    local_addr;
  logic [FW-1:0] e_in, w_in, n_in, s_in;
  logic [FW-1:0] e_out, w_out, n_out, s_out;
  logic [3:0]    eject_grant;
  logic          local_valid;
  logic [FW-1:0] local_flit;
  logic          local_ready;
  logic          fifo_full;
  logic [15:0]   eject_cnt;
  logic [15:0]   miss_cnt;

  ejector #(.DATA_W(DW), .FLIT_W(FW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .local_addr(local_addr),
    .e_in(e_in), .w_in(w_in), .n_in(n_in), .s_in(s_in),
    .e_out(e_out), .w_out(w_out), .n_out(n_out), .s_out(s_out),
    .eject_grant(eject_grant), .local_valid(local_valid),
    .local_flit(local_flit), .local_ready(local_ready),
    .fifo_full(fifo_full), .eject_cnt(eject_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] e, w, n, s;
    logic [3:0]    g;
    logic          lv;
    logic [FW-1:0] lf;
    logic          full;
    logic [15:0]   ec, mc;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] mq[$];
  int            rr;
  logic [15:0]   mec, mmc;
  int            total = 0;
  int            bad = 0;

  localparam logic [5:0] L = 6'b100100;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic v,
      input logic [5:0] d, input logic [15:0] p);
    return {v, d, p};
  endfunction

  // One cycle of stimulus; the model applies the router rules.
  task automatic cyc(input logic [FW-1:0] fe, fw, fn, fs,
                     input logic rdy);
    logic [FW-1:0] f[4];
    exp_t x;
    int   win;
    bit   anym;
    bit   full;
    @(negedge clk);
    rst_n = 1'b1;
    e_in = fe; w_in = fw; n_in = fn; s_in = fs;
    local_ready = rdy;
    f = '{fe, fw, fn, fs};
    full = (mq.size() == D);
    anym = 1'b0;
    win  = -1;
    for (int i = 0; i < 4; i++)
      if (f[i][FW-1] && f[i][FW-2:DW] == local_addr) anym = 1'b1;
    if (!full)
      for (int k = 0; k < 4; k++) begin
        int j = (rr + k) % 4;
        if (win < 0 && f[j][FW-1] && f[j][FW-2:DW] == local_addr)
          win = j;
      end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    x = '0;
    if (win >= 0) begin
      mq.push_back(f[win]);
      rr = (win + 1) % 4;
      mec = mec + 16'd1;
      f[win][FW-1] = 1'b0;
      x.g = 4'(1 << win);
    end else if (anym && mmc != 16'hFFFF) begin
      mmc = mmc + 16'd1;
    end
    x.e = f[0]; x.w = f[1]; x.n = f[2]; x.s = f[3];
    x.lv   = (mq.size() > 0);
    x.lf   = x.lv ? mq[0] : '0;
    x.full = (mq.size() == D);
    x.ec   = mec;
    x.mc   = mmc;
    exp_q.push_back(x);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete();
    rr = 0; mec = '0; mmc = '0;
    exp_q.push_back('0);
    #1;
    chk("rst_lv", 64'(local_valid), 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_eout", 64'(e_out), 64'd0);
    chk("rst_nout", 64'(n_out), 64'd0);
    chk("rst_grant", 64'(eject_grant), 64'd0);
    chk("rst_ecnt", 64'(eject_cnt), 64'd0);
    chk("rst_mcnt", 64'(miss_cnt), 64'd0);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("e_out", 64'(e_out), 64'(x.e));
        chk("w_out", 64'(w_out), 64'(x.w));
        chk("n_out", 64'(n_out), 64'(x.n));
        chk("s_out", 64'(s_out), 64'(x.s));
        chk("grant", 64'(eject_grant), 64'(x.g));
        chk("lvalid", 64'(local_valid), 64'(x.lv));
        chk("full", 64'(fifo_full), 64'(x.full));
        chk("ecnt", 64'(eject_cnt), 64'(x.ec));
        chk("mcnt", 64'(miss_cnt), 64'(x.mc));
        if (x.lv) chk("lflit", 64'(local_flit), 64'(x.lf));
      end
    end
  end

  function automatic logic [FW-1:0] rnd_flit();
    logic [5:0] d;
    d = ($urandom_range(0, 2) == 0) ? L : 6'($urandom);
    return mk(1'($urandom), d, 16'($urandom));
  endfunction

  initial begin : stim
    logic [FW-1:0] a4;
    rst_n = 1'b0;
    local_addr = L;
    local_ready = 1'b0;
    e_in = '0; w_in = '0; n_in = '0; s_in = '0;
    rr = 0; mec = '0; mmc = '0;
    do_reset(2);

    cyc('0, '0, mk(1, L, 16'hA5A5), '0, 1'b0);
    cyc('0, '0, '0, '0, 1'b1);
    cyc('0, '0, '0, '0, 1'b1);

    do_reset(1);
    for (int i = 0; i < 4; i++)
      cyc(mk(1, L, 16'h1000 + 16'(i)), mk(1, L, 16'h2000 + 16'(i)),
          mk(1, L, 16'h3000 + 16'(i)), mk(1, L, 16'h4000 + 16'(i)),
          1'b1);
    repeat (3) cyc('0, '0, '0, '0, 1'b1);

    for (int i = 0; i < 6; i++)
      cyc(mk(1, L, 16'h0B00 + 16'(i)), '0, '0, '0, 1'b0);
    cyc('0, mk(1, L, 16'h0C00), '0, '0, 1'b1);
    cyc('0, mk(1, L, 16'h0C01), '0, '0, 1'b1);
    repeat (6) cyc('0, '0, '0, '0, 1'b1);

    cyc(mk(1, 6'b101111, 16'h1234), mk(1, 6'b011001, 16'h5678),
        mk(0, L, 16'h9ABC), '0, 1'b1);

    for (int i = 0; i < 3; i++)
      cyc('0, '0, '0, mk(1, L, 16'h0D00 + 16'(i)), 1'b0);
    do_reset(1);
    a4 = mk(1, L, 16'hF00D);
    cyc(a4, a4, a4, a4, 1'b0);
    repeat (2) cyc('0, '0, '0, '0, 1'b1);

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      else cyc(rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit(),
               1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
